muldiv_unit: RTL
================

// Module: muldiv_unit
//
// PURPOSE
//   Iterative RV32M multiply/divide execute unit, directly downstream of the register file.
//   Consumes rs1/rs2 operand data plus the raw instruction word.
//   Produces the result, destination register and write enable for the register-file write port.
//   Handles MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
//   Uses one iteration per cycle; the pipeline stalls on busy.
//
// PARAMETERS
//   XLEN   32   datapath width; only 32 supported
//
// PORTS
//   clk          in   1     clock, all state updates on posedge
//   rst          in   1     reset, synchronous, active-low
//   start        in   1     request: instruction/operands valid this cycle
//   instruction  in   32    raw RV32 instruction word
//   rs1_data     in   32    operand A from register file read port 1
//   rs2_data     in   32    operand B from register file read port 2
//   busy         out  1     operation in flight; new start ignored
//   done         out  1     one-cycle pulse: result valid
//   result       out  32    operation result; held until next accept
//   rd_addr      out  5     destination register (instruction[11:7] captured at accept)
//   reg_wr_en    out  1     = done && (rd_addr != 0); drives register-file write enable
//
// BEHAVIOUR
// - Reset (posedge clk, rst==0): state IDLE. busy=0, done=0, reg_wr_en=0, result=0, rd_addr=0, counter=0.
//   - Reset has priority over everything.
//   - Reset mid-operation aborts with no done pulse.
// - Decode: M-op when opcode[6:0]=0110011 and funct7=0000001; funct3 selects op
//   (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
// - Accept when start=1 && state==IDLE && M-op.
//   - On accept: latch operands, funct3 and rd; record sign info; load magnitudes.
//   - start with a non-M instruction is ignored, with no done pulse.
//   - start while busy is ignored; there is no queueing.
// - FSM states and transitions:
//   - IDLE -> CALC on accept (normal case).
//   - IDLE -> FINISH on accept for a special-case divide.
//   - CALC -> FINISH after exactly 32 iterations (6-bit counter, 0..31).
//   - FINISH -> IDLE unconditionally.
// - busy=1 in CALC and FINISH. done=1 only in FINISH (exactly one cycle).
// - Latency, measured from the accepting edge:
//   - normal ops: done high after 33 edges;
//   - special cases: done high after 1 edge.
// - Back-to-back: a new start is accepted in the cycle where done=1 is visible? No — it is
//   accepted on the first edge where state==IDLE, i.e. the cycle after done.
// - Multiply: unsigned shift-add on magnitudes, 64-bit accumulator.
//   - Signedness: MUL/MULH signed x signed; MULHSU signed x unsigned; MULHU unsigned x unsigned.
//   - Negate the 64-bit product at FINISH if the operand signs differ.
//   - MUL returns product[31:0]; the MULH* ops return product[63:32].
// - Divide: restoring division on magnitudes; DIV/REM signed, DIVU/REMU unsigned.
//   - Quotient is negated if the operand signs differ.
//   - Remainder takes the sign of the dividend.
// - Special cases, per the RISC-V spec:
//   - Divisor == 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend.
//   - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
// - Operand inputs are ignored after accept; result and rd_addr are stable until the next FINISH.
//
// TESTING
//   1. MUL 7 x 0xFFFFFFFD (-3), rd=5 -> done exactly 33 cycles after accept;
//      result=0xFFFFFFEB, reg_wr_en=1, rd_addr=5.
//   2. Multiply variants:
//      - MULH 0x80000000 x 0x80000000 -> 0x40000000;
//      - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE;
//      - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
//   3. Divide variants:
//      - DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD;
//      - REM -7 % 2 -> 0xFFFFFFFF;
//      - DIVU 100 / 7 -> 14;
//      - REMU 100 % 7 -> 2.
//   4. Special cases, each with done 1 cycle after accept:
//      - DIV 5 / 0 -> 0xFFFFFFFF;
//      - REMU 5 / 0 -> 5;
//      - DIV 0x80000000 / -1 -> 0x80000000;
//      - REM of the same -> 0.
//   5. Sequencing hazards:
//      - start pulsed on cycle 10 of a running op -> ignored, first result unaffected,
//        exactly one done;
//      - rst=0 at iteration 10 -> busy=0 next edge, no done.
//   6. Write-enable gating:
//      - MUL with rd=x0 -> done pulses, reg_wr_en stays 0;
//      - ADD (funct7=0) with start=1 -> no busy, no done.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit feeding the register-file write port.
// One shift-add or restoring-divide step per cycle over a shared 64-bit register.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_addr,
    output logic            reg_wr_en
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t            r_state;
    logic [5:0]        r_cnt;
    logic [2*XLEN-1:0] r_p;
    logic [XLEN-1:0]   r_b;
    logic [2:0]        r_f3;
    logic [4:0]        r_rd;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd_addr;
    logic              r_wr_en;

    logic [2:0]        w_f3;
    logic              w_is_m;
    logic              w_is_div;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic              w_unused;

    assign w_f3     = instruction[14:12];
    assign w_is_m   = (instruction[6:0] == 7'b0110011)
                   && (instruction[31:25] == 7'b0000001);
    assign w_is_div = w_f3[2];
    assign w_unused = ^instruction[24:15];

    // MUL/MULH/MULHSU/DIV/REM treat rs1 as signed; only MUL/MULH/DIV/REM sign rs2
    assign w_a_signed = w_f3[2] ? ~w_f3[0] : (w_f3[1:0] != 2'b11);
    assign w_b_signed = w_f3[2] ? ~w_f3[0] : ~w_f3[1];

    assign w_a_neg = w_a_signed & rs1_data[XLEN-1];
    assign w_b_neg = w_b_signed & rs2_data[XLEN-1];
    assign w_a_mag = w_a_neg ? (~rs1_data + 1'b1) : rs1_data;
    assign w_b_mag = w_b_neg ? (~rs2_data + 1'b1) : rs2_data;

    assign w_div_zero = w_is_div && (rs2_data == '0);
    assign w_ovf      = w_is_div && !w_f3[0]
                     && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                     && (rs2_data == {XLEN{1'b1}});
    assign w_special  = w_div_zero | w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero)
            w_special_res = w_f3[1] ? rs1_data : {XLEN{1'b1}};
        else if (w_ovf)
            w_special_res = w_f3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    logic              r_is_div;
    logic [XLEN:0]     w_msum;
    logic [XLEN:0]     w_rsh;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_step;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    assign w_msum = {1'b0, r_p[2*XLEN-1:XLEN]}
                  + (r_p[0] ? {1'b0, r_b} : '0);
    assign w_rsh  = {r_p[2*XLEN-1:XLEN], r_p[XLEN-1]};
    assign w_diff = w_rsh - {1'b0, r_b};

    // Divide keeps {remainder, quotient}; multiply keeps {partial, multiplier}
    always_comb begin
        w_step = {w_msum, r_p[XLEN-1:1]};
        if (r_is_div) begin
            if (w_diff[XLEN])
                w_step = {w_rsh[XLEN-1:0], r_p[XLEN-2:0], 1'b0};
            else
                w_step = {w_diff[XLEN-1:0], r_p[XLEN-2:0], 1'b1};
        end
    end

    assign w_prod = r_neg_res ? (~w_step + 1'b1) : w_step;
    assign w_quot = r_neg_res ? (~w_step[XLEN-1:0] + 1'b1)
                              : w_step[XLEN-1:0];
    assign w_rem  = r_neg_rem ? (~w_step[2*XLEN-1:XLEN] + 1'b1)
                              : w_step[2*XLEN-1:XLEN];

    always_comb begin
        w_final = '0;
        case (r_f3)
            3'b000:                 w_final = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = w_quot;
            default:                w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_p       <= '0;
            r_b       <= '0;
            r_f3      <= '0;
            r_rd      <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_rd_addr <= '0;
            r_wr_en   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && w_is_m) begin
                        r_f3      <= w_f3;
                        r_rd      <= instruction[11:7];
                        r_is_div  <= w_is_div;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_b       <= w_is_div ? w_b_mag : w_a_mag;
                        r_p       <= {{XLEN{1'b0}},
                                      (w_is_div ? w_a_mag : w_b_mag)};
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        if (w_special) begin
                            r_result  <= w_special_res;
                            r_rd_addr <= instruction[11:7];
                            r_done    <= 1'b1;
                            r_wr_en   <= (instruction[11:7] != 5'd0);
                            r_state   <= FINISH;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_p <= w_step;
                    if (r_cnt == 6'd31) begin
                        r_cnt     <= '0;
                        r_result  <= w_final;
                        r_rd_addr <= r_rd;
                        r_done    <= 1'b1;
                        r_wr_en   <= (r_rd != 5'd0);
                        r_state   <= FINISH;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                FINISH: begin
                    r_done  <= 1'b0;
                    r_wr_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_wr_en <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign rd_addr   = r_rd_addr;
    assign reg_wr_en = r_wr_en;

endmodule
